// File: rtl/i2s_rx.sv
// I2S (Philips format) slave receiver: oversamples sclk/ws/sd in the clk domain
// and deserialises frames into left-justified signed left/right samples.
module i2s_rx #(
  parameter int SAMPLE_WIDTH  = 24,
  parameter int MAX_SLOT_BITS = 64
) (
  input  logic                    clk,
  input  logic                    ic_n,
  input  logic                    i2s_sclk,
  input  logic                    i2s_ws,
  input  logic                    i2s_sd,
  output logic                    sample_valid,
  output logic [SAMPLE_WIDTH-1:0] sample_l,
  output logic [SAMPLE_WIDTH-1:0] sample_r,
  output logic                    frame_err,
  output logic                    locked
);

  localparam int CW = $clog2(MAX_SLOT_BITS + 1);
  localparam logic [CW-1:0] SW_C  = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_SLOT_BITS);

  typedef enum logic {SYNC_WAIT, RUN} state_t;

  state_t                  state;
  logic                    sclk_m, sclk_s, sclk_d;
  logic                    ws_m, ws_s;
  logic                    sd_m, sd_s;
  logic                    rise;
  logic                    ws_prev;
  logic [CW-1:0]           bit_cnt;
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [SAMPLE_WIDTH-1:0] left_hold;

  logic [SAMPLE_WIDTH-1:0] shifted;
  logic [CW-1:0]           captured;
  logic [SAMPLE_WIDTH-1:0] commit;
  logic                    short_slot;

  // All three inputs see the same two-flop delay so ws/sd line up with the rise.
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      sclk_m <= 1'b0;
      sclk_s <= 1'b0;
      sclk_d <= 1'b0;
      ws_m   <= 1'b0;
      ws_s   <= 1'b0;
      sd_m   <= 1'b0;
      sd_s   <= 1'b0;
    end else begin
      sclk_m <= i2s_sclk;
      sclk_s <= sclk_m;
      sclk_d <= sclk_s;
      ws_m   <= i2s_ws;
      ws_s   <= ws_m;
      sd_m   <= i2s_sd;
      sd_s   <= sd_m;
    end
  end

  assign rise = sclk_s & ~sclk_d;

  always_comb begin
    shifted    = shreg;
    captured   = SW_C;
    if (bit_cnt < SW_C) begin
      shifted  = {shreg[SAMPLE_WIDTH-2:0], sd_s};
      captured = bit_cnt + CW'(1);
    end
    commit     = shifted << (SW_C - captured);
    short_slot = (captured < SW_C);
  end

  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state        <= SYNC_WAIT;
      ws_prev      <= 1'b0;
      bit_cnt      <= '0;
      shreg        <= '0;
      left_hold    <= '0;
      sample_valid <= 1'b0;
      sample_l     <= '0;
      sample_r     <= '0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      if (rise) begin
        case (state)
          SYNC_WAIT: begin
            ws_prev <= ws_s;
            if (ws_prev && !ws_s) begin
              state   <= RUN;
              locked  <= 1'b1;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          RUN: begin
            if (ws_s == ws_prev) begin
              if (bit_cnt < SW_C) shreg <= shifted;
              bit_cnt <= (bit_cnt == MAX_C) ? MAX_C : bit_cnt + CW'(1);
              if (bit_cnt == MAX_C - CW'(1)) begin
                frame_err <= 1'b1;
                state     <= SYNC_WAIT;
                locked    <= 1'b0;
                shreg     <= '0;
                left_hold <= '0;
              end
            end else begin
              // ws flipped: this bit is the last bit of the ending channel
              frame_err <= short_slot;
              if (ws_prev) begin
                sample_l     <= left_hold;
                sample_r     <= commit;
                sample_valid <= 1'b1;
              end else begin
                left_hold <= commit;
              end
              shreg   <= '0;
              bit_cnt <= '0;
              ws_prev <= ws_s;
            end
          end
          default: state <= SYNC_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: the bench serialises Philips frames itself and
// checks received pairs against a queue of expected samples.
module tb_i2s_rx;

  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          ic_n = 1'b0;
  logic          i2s_sclk = 1'b0;
  logic          i2s_ws = 1'b0;
  logic          i2s_sd = 1'b0;
  logic          sample_valid;
  logic [SW-1:0] sample_l;
  logic [SW-1:0] sample_r;
  logic          frame_err;
  logic          locked;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int n_both   = 0;
  int v0, e0, b0;

  logic [2*SW-1:0] exp_q[$];
  logic [2*SW-1:0] exp_e;

  always #5 clk = ~clk;

  i2s_rx #(.SAMPLE_WIDTH(SW), .MAX_SLOT_BITS(64)) dut (
    .clk(clk), .ic_n(ic_n), .i2s_sclk(i2s_sclk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .sample_valid(sample_valid), .sample_l(sample_l), .sample_r(sample_r),
    .frame_err(frame_err), .locked(locked)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_err) n_err++;
    if (frame_err && sample_valid) n_both++;
    if (sample_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("sample_l", {40'd0, sample_l}, {40'd0, exp_e[2*SW-1:SW]});
        check("sample_r", {40'd0, sample_r}, {40'd0, exp_e[SW-1:0]});
      end
    end
  end

  // sclk low for 2 clk then high for 2 clk; ws/sd change while sclk is low
  task automatic send_bit(input logic ws, input logic sd);
    @(negedge clk);
    i2s_sclk = 1'b0;
    i2s_ws   = ws;
    i2s_sd   = sd;
    repeat (2) @(negedge clk);
    i2s_sclk = 1'b1;
    @(negedge clk);
  endtask

  // word is left-justified in 64 bits; the last bit of a slot carries the next ws
  task automatic send_part(input logic [63:0] word, input logic wsb, input int slot,
                           input int from, input int to);
    for (int i = from; i < to; i++)
      send_bit((i == slot - 1) ? ~wsb : wsb, word[63-i]);
  endtask

  task automatic send_frame(input logic [63:0] l, input logic [63:0] r, input int slot);
    send_part(l, 1'b0, slot, 0, slot);
    send_part(r, 1'b1, slot, 0, slot);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {63'd0, sample_valid}, 64'd0);
    check({tag, "_l"}, {40'd0, sample_l}, 64'd0);
    check({tag, "_r"}, {40'd0, sample_r}, 64'd0);
    check({tag, "_err"}, {63'd0, frame_err}, 64'd0);
    check({tag, "_locked"}, {63'd0, locked}, 64'd0);
  endtask

  initial begin
    // Reset state
    wait_clks(3);
    check_outputs_zero("reset");
    ic_n = 1'b1;
    wait_clks(2);

    // Three 32-bit frames: first one only locks
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({24'h123456, 24'hABCDEF});
    exp_q.push_back({24'h123456, 24'hABCDEF});
    for (int f = 0; f < 3; f++)
      send_frame({24'h123456, 40'd0}, {24'hABCDEF, 40'd0}, 32);
    wait_clks(8);
    check("basic_valid_cnt", 64'(n_valid - v0), 64'd2);
    check("basic_err_cnt", 64'(n_err - e0), 64'd0);
    check("basic_locked", {63'd0, locked}, 64'd1);

    // Full-scale extremes, already locked: one pair per frame
    v0 = n_valid; e0 = n_err;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({24'h800000, 24'h7FFFFF});
      send_frame({24'h800000, 40'd0}, {24'h7FFFFF, 40'd0}, 32);
    end
    wait_clks(8);
    check("extreme_valid_cnt", 64'(n_valid - v0), 64'd3);
    check("extreme_err_cnt", 64'(n_err - e0), 64'd0);

    // 16-bit slots: zero-padded LSBs, two short-slot errors per frame
    v0 = n_valid; e0 = n_err; b0 = n_both;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back({24'h800100, 24'h00FF00});
      send_frame({16'h8001, 48'd0}, {16'h00FF, 48'd0}, 16);
    end
    wait_clks(8);
    check("short_valid_cnt", 64'(n_valid - v0), 64'd2);
    check("short_err_cnt", 64'(n_err - e0), 64'd4);
    check("short_err_with_valid", 64'(n_both - b0), 64'd2);

    // ws stuck low: overrun exactly at bit 64
    v0 = n_valid; e0 = n_err;
    for (int i = 0; i < 63; i++) send_bit(1'b0, 1'b1);
    wait_clks(6);
    check("overrun_bit63_locked", {63'd0, locked}, 64'd1);
    check("overrun_bit63_err", 64'(n_err - e0), 64'd0);
    send_bit(1'b0, 1'b1);
    wait_clks(6);
    check("overrun_bit64_locked", {63'd0, locked}, 64'd0);
    check("overrun_bit64_err", 64'(n_err - e0), 64'd1);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1);
    send_frame({24'h0F0F0F, 40'd0}, {24'hF0F0F0, 40'd0}, 32);
    wait_clks(6);
    check("relock_locked", {63'd0, locked}, 64'd1);
    check("overrun_no_valid", 64'(n_valid - v0), 64'd0);
    exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
    send_frame({24'h0F0F0F, 40'd0}, {24'hF0F0F0, 40'd0}, 32);
    wait_clks(8);
    check("relock_valid_cnt", 64'(n_valid - v0), 64'd1);
    check("overrun_err_total", 64'(n_err - e0), 64'd1);

    // sclk stalled mid left slot
    v0 = n_valid; e0 = n_err;
    exp_q.push_back({24'h5A5A5A, 24'hC3C3C3});
    send_part({24'h5A5A5A, 40'd0}, 1'b0, 32, 0, 10);
    wait_clks(1000);
    check("stall_no_valid", 64'(n_valid - v0), 64'd0);
    check("stall_no_err", 64'(n_err - e0), 64'd0);
    check("stall_locked", {63'd0, locked}, 64'd1);
    send_part({24'h5A5A5A, 40'd0}, 1'b0, 32, 10, 32);
    send_part({24'hC3C3C3, 40'd0}, 1'b1, 32, 0, 32);
    wait_clks(8);
    check("stall_valid_cnt", 64'(n_valid - v0), 64'd1);
    check("stall_err_cnt", 64'(n_err - e0), 64'd0);

    // Reset at bit 10 of a right slot
    v0 = n_valid;
    send_part({24'h111111, 40'd0}, 1'b0, 32, 0, 32);
    send_part({24'h222222, 40'd0}, 1'b1, 32, 0, 10);
    @(negedge clk);
    ic_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
    send_part({24'h222222, 40'd0}, 1'b1, 32, 10, 32);
    wait_clks(6);
    check("midreset_relock", {63'd0, locked}, 64'd1);
    check("midreset_no_valid", 64'(n_valid - v0), 64'd0);
    exp_q.push_back({24'h765432, 24'h89ABCD});
    send_frame({24'h765432, 40'd0}, {24'h89ABCD, 40'd0}, 32);
    wait_clks(8);
    check("midreset_valid_cnt", 64'(n_valid - v0), 64'd1);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (slave): the receiving end of the serial link our `i2s` transmitter drives.
- Oversamples externally generated `i2s_sclk`/`i2s_ws`/`i2s_sd` in the `clk` domain and deserialises Philips-format frames into signed left/right samples.
- Emits one `sample_valid` pulse per stereo frame, with the same `sample_valid`/`sample_l`/`sample_r` signalling the opl3 core produces.
- Used as a line-in path and as a loopback checker for the transmitter.

Parameters:
- `SAMPLE_WIDTH`, 24, bits per output sample; MSB-first capture.
- `MAX_SLOT_BITS`, 64, maximum sclk edges per channel slot before a loss-of-frame error.

Ports:
- `clk` input 1: system clock; must be ≥4× `i2s_sclk` frequency.
- `ic_n` input 1: reset, asynchronous, active-low.
- `i2s_sclk` input 1: serial bit clock, asynchronous to `clk`.
- `i2s_ws` input 1: word select; 0 = left, 1 = right.
- `i2s_sd` input 1: serial data, MSB first.
- `sample_valid` output 1: one-clk pulse, new stereo pair on `sample_l`/`sample_r`.
- `sample_l` output `SAMPLE_WIDTH`: signed left sample; held between pulses.
- `sample_r` output `SAMPLE_WIDTH`: signed right sample; held between pulses.
- `frame_err` output 1: one-clk pulse on short slot or slot overrun.
- `locked` output 1: high while in RUN state.

Behaviour:
- **Reset:** `ic_n` low asynchronously clears all state. Outputs: `sample_valid`=0, `sample_l`=0, `sample_r`=0, `frame_err`=0, `locked`=0. State = SYNC_WAIT. Synchronisers clear to 0.
- **Input sync:** each of `i2s_sclk`/`i2s_ws`/`i2s_sd` passes through a 2-flop synchroniser. A third `sclk` flop feeds edge detection: `rise = sclk_s & ~sclk_d`. `ws_s` and `sd_s` are sampled only in `rise` cycles; all three paths have equal delay.
- **Bit event:** a `rise` cycle. It compares sampled `ws` against `ws_prev`, which holds `ws` from the previous bit event.
- **SYNC_WAIT:**
  - Waits for a bit event with `ws_prev`=1 and `ws`=0 (right→left boundary).
  - On that event: `bit_cnt`=0, `ws_prev`=0, go to RUN, `locked`=1.
  - All data before this event is discarded.
- **RUN, bit event with `ws`==`ws_prev`:**
  - If `bit_cnt` < `SAMPLE_WIDTH`, shift `sd` into the current-channel shift register (LSB in).
  - `bit_cnt` increments and saturates at `MAX_SLOT_BITS`.
  - If `bit_cnt` reaches `MAX_SLOT_BITS`: pulse `frame_err`, go to SYNC_WAIT, `locked`=0, discard the partial frame.
- **RUN, bit event with `ws`!=`ws_prev`:**
  - This bit is the final bit of the ending channel (I2S one-bit WS lead). Shift it in under the same `SAMPLE_WIDTH` rule, then commit that channel.
  - Commit value = shift register left-shifted by (`SAMPLE_WIDTH` − bits captured), i.e. left-justified with zero-padded LSBs. Bits beyond `SAMPLE_WIDTH` are ignored.
  - If bits captured < `SAMPLE_WIDTH`, pulse `frame_err`; the sample is still committed.
  - Then clear the shift register, set `bit_cnt`=0, set `ws_prev`=`ws`.
- **Channel commits:**
  - Left commit (0→1) goes to an internal `left_hold` only.
  - Right commit (1→0) updates `sample_l`←`left_hold` and `sample_r`←committed right, and pulses `sample_valid`.
- **Latency:** `sample_valid`, `frame_err` and the sample registers update on the `clk` edge ending the bit-event cycle. Worst case is 4 `clk` cycles from the `sclk` rising edge at the pin.
- **Simultaneous errors:** a short right slot asserts `frame_err` and `sample_valid` in the same cycle.
- **First output after lock:** the first `sample_valid` after lock follows one complete left+right pair. It never carries a stale or partial left sample.
- **Stalled `sclk`:** no events and no outputs; state and outputs hold indefinitely.
- **Reset mid-word:** partial data is discarded; relock is required via SYNC_WAIT.

Test Plan:
- Reset, then 3 frames of 32-bit slots, L=24'h123456, R=24'hABCDEF (8 trailing zero bits), `clk`=4×`sclk` → first frame discarded until lock; then exactly one `sample_valid` per frame with `sample_l`=24'h123456, `sample_r`=24'hABCDEF, `frame_err` never asserted.
- Loopback: our `i2s` transmitter → `i2s_rx`, transmitter fed L=24'h800000, R=24'h7FFFFF → received values match, one frame delay, `sample_valid` every frame.
- 16-bit slots, L=16'h8001, R=16'h00FF → `sample_l`=24'h800100, `sample_r`=24'h00FF00, `frame_err` pulses twice per frame.
- `ws` held at 0 for 70 `sclk` cycles mid-stream → `frame_err` pulse at bit 64, `locked`→0, no `sample_valid`. Resumed normal frames → relock, and the first `sample_valid` follows one full pair.
- `ic_n` asserted for 2 `clk` at bit 10 of a right slot → all outputs 0 immediately. After release, no `sample_valid` until after the next 1→0 `ws` boundary plus a full L/R pair.
- `sclk` stopped for 1000 `clk` mid left slot, then resumed → no spurious pulses; the frame completes with correct values and `frame_err`=0.
